// File: rtl/vdp_tile_row_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_tile_row_decoder_pkg
//  Description : Shared definitions for the tile row decoder: map-word field
//                positions, fill FSM encoding and the pixel select helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vdp_tile_row_decoder_pkg;

  // Map-word field positions
  localparam int XFLIP_BIT       = 9;
  localparam int YFLIP_BIT       = 10;
  localparam int TILE_NUMBER_MSB = 8;
  localparam int PALETTE_LSB     = 12;

  // Row geometry
  localparam int PIXELS_PER_ROW  = 8;
  localparam int PIX_IDX_W       = 3;
  localparam int ROW_BITS        = 32;
  localparam int NUM_BANKS       = 2;

  // Fill side state encoding
  typedef enum logic [1:0] {
    FILL_IDLE  = 2'd0,
    FILL_WORD0 = 2'd1,
    FILL_WORD1 = 2'd2
  } fill_state_e;

  // Colour of output slot idx; with xflip the row is read back to front.
  function automatic logic [3:0] row_color(input logic [ROW_BITS-1:0]  row,
                                           input logic [PIX_IDX_W-1:0] idx,
                                           input logic                 xflip);
    logic [PIX_IDX_W-1:0] phys;
    phys = xflip ? ~idx : idx;
    return row[{phys, 2'b00} +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vdp_tile_row_bank.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_tile_row_bank
//  Description : One ping-pong bank: a 32-bit tile row, its palette, xflip and
//                full flag. Presents the pixel selected from the next-state
//                contents so the parent can register it in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module vdp_tile_row_bank
  import vdp_tile_row_decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_we_i,
  input  logic                 cfg_xflip_i,
  input  logic [3:0]           cfg_palette_i,
  input  logic                 lo_we_i,
  input  logic                 hi_we_i,
  input  logic [15:0]          word_i,
  input  logic                 drain_done_i,
  input  logic [PIX_IDX_W-1:0] idx_i,
  output logic                 full_o,
  output logic                 full_next_o,
  output logic [7:0]           pix_next_o
);

  logic [ROW_BITS-1:0] row_q,     row_d;
  logic [3:0]          palette_q, palette_d;
  logic                xflip_q,   xflip_d;
  logic                full_q,    full_d;

  // Next-state for row storage, attributes and full flag
  always_comb begin
    row_d     = row_q;
    palette_d = palette_q;
    xflip_d   = xflip_q;
    full_d    = full_q;
    if (cfg_we_i) begin
      palette_d = cfg_palette_i;
      xflip_d   = cfg_xflip_i;
    end
    if (lo_we_i) begin
      row_d[15:0] = word_i;
    end
    // A bank is never filled and drained at once: filling requires it empty.
    if (hi_we_i) begin
      row_d[31:16] = word_i;
      full_d       = 1'b1;
    end else if (drain_done_i) begin
      full_d = 1'b0;
    end
  end

  // Bank state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q     <= '0;
      palette_q <= 4'd0;
      xflip_q   <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      row_q     <= row_d;
      palette_q <= palette_d;
      xflip_q   <= xflip_d;
      full_q    <= full_d;
    end
  end

  assign full_o      = full_q;
  assign full_next_o = full_d;
  assign pix_next_o  = {palette_d, row_color(row_d, idx_i, xflip_d)};

endmodule
`default_nettype wire

// File: rtl/vdp_tile_row_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_tile_row_decoder
//  Description : Tile row decoder. Takes a map word plus two VRAM row words,
//                fills one of two banks and streams 8 palette-tagged 4bpp
//                pixels per row over a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module vdp_tile_row_decoder #(
  parameter int XFLIP_BIT   = vdp_tile_row_decoder_pkg::XFLIP_BIT,
  parameter int PALETTE_LSB = vdp_tile_row_decoder_pkg::PALETTE_LSB
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        map_valid,
  output logic        map_ready,
  input  logic [15:0] map_data,
  input  logic        vram_valid,
  input  logic [15:0] vram_data,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic [7:0]  pixel,
  output logic        pixel_opaque,
  output logic        row_last,
  output logic        protocol_error
);
  import vdp_tile_row_decoder_pkg::*;

  fill_state_e          state_q, state_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [PIX_IDX_W-1:0] idx_q, idx_d;
  logic                 perr_q, perr_d;
  logic [7:0]           pixel_q, pixel_d;
  logic                 opaque_q, opaque_d;
  logic                 last_q, last_d;

  logic [NUM_BANKS-1:0]      w_cfg_we;
  logic [NUM_BANKS-1:0]      w_lo_we;
  logic [NUM_BANKS-1:0]      w_hi_we;
  logic [NUM_BANKS-1:0]      w_drain_done;
  logic [NUM_BANKS-1:0]      w_full;
  logic [NUM_BANKS-1:0]      w_full_next;
  logic [NUM_BANKS-1:0][7:0] w_pix_next;
  logic                      w_fire;
  logic                      w_valid_next;
  logic [7:0]                w_pix_sel;
  logic                      w_unused_map;

  // Only the flip and palette fields are consumed here.
  assign w_unused_map = ^map_data;

  // map_ready looks at the registered empty flag, so a bank freed this cycle
  // is offered to the map side one cycle later.
  assign map_ready   = (state_q == FILL_IDLE) && !w_full[wr_bank_q];
  assign pixel_valid = w_full[rd_bank_q];
  assign w_fire      = pixel_valid && pixel_ready;

  // Fill FSM: next state and write strobes for the current write bank
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    perr_d    = perr_q;
    w_cfg_we  = '0;
    w_lo_we   = '0;
    w_hi_we   = '0;
    case (state_q)
      FILL_IDLE: begin
        if (vram_valid) begin
          perr_d = 1'b1;
        end
        if (map_valid && map_ready) begin
          w_cfg_we[wr_bank_q] = 1'b1;
          state_d             = FILL_WORD0;
        end
      end
      FILL_WORD0: begin
        if (vram_valid) begin
          w_lo_we[wr_bank_q] = 1'b1;
          state_d            = FILL_WORD1;
        end
      end
      FILL_WORD1: begin
        if (vram_valid) begin
          w_hi_we[wr_bank_q] = 1'b1;
          wr_bank_d          = ~wr_bank_q;
          state_d            = FILL_IDLE;
        end
      end
      default: begin
        state_d = FILL_IDLE;
      end
    endcase
  end

  // Drain side: advance the pixel index and retire the bank after pixel 7
  always_comb begin
    idx_d        = idx_q;
    rd_bank_d    = rd_bank_q;
    w_drain_done = '0;
    if (w_fire) begin
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'(PIXELS_PER_ROW - 1)) begin
        w_drain_done[rd_bank_q] = 1'b1;
        rd_bank_d               = ~rd_bank_q;
      end
    end
  end

  // Output register inputs, taken from the bank contents as they will be
  // after this edge so the pixel lines up with pixel_valid.
  always_comb begin
    w_valid_next = w_full_next[rd_bank_d];
    w_pix_sel    = w_pix_next[rd_bank_d];
    pixel_d      = w_valid_next ? w_pix_sel : 8'd0;
    opaque_d     = w_valid_next && (|w_pix_sel[3:0]);
    last_d       = w_valid_next && (idx_d == 3'(PIXELS_PER_ROW - 1));
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FILL_IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      idx_q     <= '0;
      perr_q    <= 1'b0;
      pixel_q   <= 8'd0;
      opaque_q  <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      idx_q     <= idx_d;
      perr_q    <= perr_d;
      pixel_q   <= pixel_d;
      opaque_q  <= opaque_d;
      last_q    <= last_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      vdp_tile_row_bank u_bank (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_we_i      (w_cfg_we[gi]),
        .cfg_xflip_i   (map_data[XFLIP_BIT]),
        .cfg_palette_i (map_data[PALETTE_LSB +: 4]),
        .lo_we_i       (w_lo_we[gi]),
        .hi_we_i       (w_hi_we[gi]),
        .word_i        (vram_data),
        .drain_done_i  (w_drain_done[gi]),
        .idx_i         (idx_d),
        .full_o        (w_full[gi]),
        .full_next_o   (w_full_next[gi]),
        .pix_next_o    (w_pix_next[gi])
      );
    end
  endgenerate

  assign pixel          = pixel_q;
  assign pixel_opaque   = opaque_q;
  assign row_last       = last_q;
  assign protocol_error = perr_q;

endmodule
`default_nettype wire

// File: doc/vdp_tile_row_decoder.md
Name: vdp_tile_row_decoder

Overview:
- Consumer end of the tile fetch path. Receives the map word that selected a tile, then the two VRAM words of the addressed tile row.
- Unpacks 8 × 4bpp pixels, applies X-flip and the palette from the map word, and streams 8-bit pixels to the line-buffer writer over a valid/ready handshake.
- Two-bank ping-pong buffer: the next row can be fetched while the current row drains.

Parameters:
- XFLIP_BIT, 9, map_data bit selecting horizontal flip
- PALETTE_LSB, 12, LSB of the 4-bit palette field in map_data (bits PALETTE_LSB+3:PALETTE_LSB)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- map_valid  in  1  map_data valid for this tile
- map_ready  out  1  decoder can accept a new map word
- map_data  in  16  map word: tile attributes (flip, palette)
- vram_valid  in  1  vram_data carries the next tile-row word
- vram_data  in  16  tile row word, 4 pixels, pixel n in bits 4n+3:4n
- pixel_valid  out  1  pixel output valid
- pixel_ready  in  1  downstream accepts pixel
- pixel  out  8  {palette[3:0], color[3:0]}
- pixel_opaque  out  1  color != 0
- row_last  out  1  marks pixel 7 of a row
- protocol_error  out  1  sticky: vram_valid received while not awaiting a word

Behaviour:
- Reset (async assert, sync deassert use): fill FSM in IDLE, both banks empty, write bank 0, read bank 0, pixel index 0. All outputs 0 except map_ready, which reads 1 from the first cycle after reset.
- Fill FSM states:
  - IDLE: map_ready = (write bank empty). On map_valid && map_ready, latch xflip and palette, go to WORD0.
  - WORD0: on vram_valid, store vram_data as pixels 0-3, go to WORD1.
  - WORD1: on vram_valid, store pixels 4-7. Mark the write bank full, toggle the write bank, go to IDLE.
- map_ready is 0 in WORD0 and WORD1. map_valid is ignored unless map_ready is 1.
- vram_valid in IDLE: the word is discarded and protocol_error is set. protocol_error is cleared only by reset.
- Drain side:
  - pixel_valid = (read bank full). pixel, pixel_opaque and row_last are all registered from the bank contents.
  - Output ordering: with xflip = 0, pixels are emitted in order 0..7; with xflip = 1, in order 7..0. pixel[7:4] = that bank's palette.
  - On pixel_valid && pixel_ready, the pixel index increments.
  - The handshake that accepts index 7 (row_last = 1) marks the bank empty, toggles the read bank and resets the index to 0.
  - pixel_valid may stay high across rows with no bubble when the other bank is full.
- Latency: the handshake accepting WORD1 on cycle N makes the bank full at N+1. pixel_valid rises at N+1 when that bank is the read bank.
- Throughput: 1 pixel/clock sustained. The fill side needs at least 3 cycles per row, so the drain is the bottleneck.
- Simultaneous events:
  - A bank emptied by the drain and a map word arriving in the same cycle: map_ready uses the registered empty flag, so the new map word is accepted the next cycle.
  - A bank completing fill while the other bank drains its last pixel: both updates apply in that cycle with no loss.
- pixel_ready low: pixel, pixel_opaque and row_last are held stable while pixel_valid is high.
- Reset mid-row discards all partial and buffered data.
- Width rules:
  - The palette field is extracted unchanged.
  - pixel_opaque = |color.
  - The pixel index is a 3-bit counter that wraps naturally at the row end.

Decomposition:
- Shared vdp package:
  - map-word field constants (XFLIP_BIT=9, YFLIP_BIT=10, TILE_NUMBER_MSB=8, PALETTE_LSB=12)
  - fill state encoding (IDLE/WORD0/WORD1)
  - PIXELS_PER_ROW=8
- One natural sub-module, vdp_tile_row_bank: storage for one 32-bit row plus palette, xflip and full flag, with a flip-aware pixel select. Instantiated twice.

Test Plan:
- Single row, no flip: map 0x3000, words 0x3210 then 0x7654, pixel_ready = 1 → pixels 0x30..0x37 on consecutive cycles. Pixel 0 has pixel_opaque = 0. row_last on 0x37. First pixel_valid 1 cycle after WORD1 is accepted.
- X-flip: map 0x5200, words 0x3210 and 0x7654 → pixels 0x57, 0x56 … 0x50. row_last on 0x50.
- Back-to-back rows: 3 rows fed as fast as map_ready allows, pixel_ready = 1 → 24 pixels with pixel_valid continuous after the first. map_ready drops while both banks are full.
- Backpressure: pixel_ready toggles 1/0 each cycle → each pixel is held stable while stalled and no pixel is lost or duplicated. A third map word is stalled until row 1 fully drains.
- Protocol error: vram_valid pulse in IDLE → protocol_error = 1 and stays 1; the subsequent normal row still decodes correctly.
- Reset mid-fill: reset_n asserted in WORD1 → pixel_valid = 0, map_ready = 1 after release. The next row decodes correctly from bank 0.
